// File: rtl/passcode_pkg.sv
// Shared types and helpers for the passcode checker: FSM state encoding,
// default digit width and the Digit_count width function.
package passcode_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_CHECK    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  localparam int DIGIT_W_DEF = 4;
  localparam int TRY_W       = 4;  // MAX_TRIES is at most 15

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter for the lockout window: load sets LOCK_CYCLES-1, en counts
// down to zero and holds there; done is high at zero.
module lockout_timer #(
  parameter int LOCK_CYCLES = 1000
)(
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                    cnt_q <= '0;
    else if (load)               cnt_q <= LOAD_VAL;
    else if (en && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/passcode_checker.sv
// Passcode entry FSM: shifts committed digits, compares against the stored
// code, counts failures and enforces a timed lockout.
// Optional macro PASSCODE_PROGRAM_EN adds Set_pulse to reprogram the code while unlocked.
module passcode_checker
  import passcode_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = DIGIT_W_DEF,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
)(
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             En,
  input  logic [DIGIT_W-1:0]               Digit_in,
  input  logic                             Shift_pulse,
  input  logic                             Lock_req,
`ifdef PASSCODE_PROGRAM_EN
  input  logic                             Set_pulse,
`endif
  output logic                             Unlocked,
  output logic                             Fail,
  output logic                             Locked_out,
  output logic [cnt_w(NUM_DIGITS)-1:0]     Digit_count
);

  localparam int EW = NUM_DIGITS * DIGIT_W;
  localparam int CW = cnt_w(NUM_DIGITS);
  localparam logic [CW-1:0]    LAST_DIGIT = CW'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0] TRY_MAX    = TRY_W'(MAX_TRIES);

  state_t            state_q, state_d;
  logic [EW-1:0]     entry_q;
  logic [CW-1:0]     cnt_q;
  logic [TRY_W-1:0]  tries_q;
  logic              fail_q;
  logic [EW-1:0]     code;

  logic shift_en, clr_entry, try_inc, try_clr, fail_d, tmr_load, tmr_done;
  logic code_ld;

`ifdef PASSCODE_PROGRAM_EN
  logic [EW-1:0] code_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)         code_q <= DEFAULT_CODE;
    else if (code_ld) code_q <= entry_q;
  end
  assign code = code_q;
`else
  assign code = DEFAULT_CODE;
`endif

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    clr_entry = 1'b0;
    try_inc   = 1'b0;
    try_clr   = 1'b0;
    fail_d    = 1'b0;
    tmr_load  = 1'b0;
    code_ld   = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (En && Shift_pulse) begin
          shift_en = 1'b1;
          state_d  = (cnt_q == LAST_DIGIT) ? S_CHECK : S_ENTRY;
        end
      end
      // Completes regardless of En so a full entry is never stranded.
      S_CHECK: begin
        clr_entry = 1'b1;
        if (entry_q == code) begin
          state_d = S_UNLOCKED;
          try_clr = 1'b1;
        end else begin
          fail_d  = 1'b1;
          try_inc = 1'b1;
          if (int'(tries_q) + 1 >= MAX_TRIES) begin
            state_d  = S_LOCKOUT;
            tmr_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_UNLOCKED: begin
        if (En && Lock_req) begin
          state_d   = S_IDLE;
          clr_entry = 1'b1;
        end
`ifdef PASSCODE_PROGRAM_EN
        else if (En && Set_pulse && cnt_q == CW'(NUM_DIGITS)) begin
          code_ld   = 1'b1;
          clr_entry = 1'b1;
        end else if (En && Shift_pulse && cnt_q != CW'(NUM_DIGITS)) begin
          shift_en = 1'b1;
        end
`endif
      end
      S_LOCKOUT: begin
        if (tmr_done) begin
          state_d = S_IDLE;
          try_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      if (clr_entry) begin
        entry_q <= '0;
        cnt_q   <= '0;
      end else if (shift_en) begin
        entry_q <= {entry_q[EW-DIGIT_W-1:0], Digit_in};
        cnt_q   <= cnt_q + 1'b1;
      end
      if (try_clr)                          tries_q <= '0;
      else if (try_inc && tries_q != TRY_MAX) tries_q <= tries_q + 1'b1;
    end
  end

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (tmr_load),
    .en   (state_q == S_LOCKOUT),
    .done (tmr_done)
  );

  assign Unlocked    = (state_q == S_UNLOCKED);
  assign Locked_out  = (state_q == S_LOCKOUT);
  assign Fail        = fail_q;
  assign Digit_count = cnt_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Self-checking bench for passcode_checker: directed vector table, corner
// sequences, and random traffic against a queue-based reference model.
module tb_passcode_checker;

  localparam int N    = 4;
  localparam int MAXT = 3;
  localparam int LOCK = 20;
  localparam logic [15:0] DEF_CODE = 16'h1234;

  logic       Clk, Rst, En, Shift_pulse, Lock_req;
  logic [3:0] Digit_in;
  logic       Unlocked, Fail, Locked_out;
  logic [2:0] Digit_count;
`ifdef PASSCODE_PROGRAM_EN
  logic       Set_pulse;
`endif

  int checks = 0;
  int errors = 0;

  passcode_checker #(
    .NUM_DIGITS(N), .DIGIT_W(4), .DEFAULT_CODE(DEF_CODE),
    .MAX_TRIES(MAXT), .LOCK_CYCLES(LOCK)
  ) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Digit_in(Digit_in),
    .Shift_pulse(Shift_pulse), .Lock_req(Lock_req),
`ifdef PASSCODE_PROGRAM_EN
    .Set_pulse(Set_pulse),
`endif
    .Unlocked(Unlocked), .Fail(Fail), .Locked_out(Locked_out),
    .Digit_count(Digit_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model: digits held in a queue, lockout as cycles remaining.
  logic [3:0]  m_q[$];
  logic        m_pend, m_unl, m_fail;
  int          m_tries, m_lock;
  logic [15:0] m_code;

  function automatic logic [15:0] qval();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + int'(m_q[i]);
    return 16'(v);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pend = 0; m_unl = 0; m_fail = 0; m_tries = 0; m_lock = 0;
    m_code = DEF_CODE;
  endfunction

  function automatic void model_edge(logic en, logic sh, logic [3:0] d, logic lr);
    m_fail = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = 0;
    end else if (m_pend) begin
      m_pend = 0;
      if (qval() == m_code) begin
        m_unl = 1; m_tries = 0;
      end else begin
        m_fail = 1; m_tries++;
        if (m_tries >= MAXT) m_lock = LOCK;
      end
      m_q.delete();
    end else if (m_unl) begin
      if (en && lr) begin
        m_unl = 0; m_q.delete();
      end
`ifdef PASSCODE_PROGRAM_EN
      else if (en && Set_pulse && m_q.size() == N) begin
        m_code = qval(); m_q.delete();
      end else if (en && sh && m_q.size() < N) m_q.push_back(d);
`endif
    end else if (en && sh) begin
      m_q.push_back(d);
      if (m_q.size() == N) m_pend = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model Unlocked", int'(Unlocked), int'(m_unl));
    chk("model Fail", int'(Fail), int'(m_fail));
    chk("model Locked_out", int'(Locked_out), int'(m_lock > 0));
    chk("model Digit_count", int'(Digit_count), m_q.size());
  endtask

  task automatic step(input logic en, input logic sh, input logic [3:0] d, input logic lr);
    En = en; Shift_pulse = sh; Digit_in = d; Lock_req = lr;
    @(posedge Clk);
    model_edge(en, sh, d, lr);
    #1;
    chk_model();
  endtask

  task automatic idle(); step(1'b1, 1'b0, 4'd0, 1'b0); endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) step(1'b1, 1'b1, code[i*4 +: 4], 1'b0);
  endtask

  task automatic do_reset();
    #2 Rst = 1'b0;
    model_reset();
    #1;
    chk("reset Unlocked", int'(Unlocked), 0);
    chk("reset Fail", int'(Fail), 0);
    chk("reset Locked_out", int'(Locked_out), 0);
    chk("reset Digit_count", int'(Digit_count), 0);
    repeat (2) @(posedge Clk);
    #2 Rst = 1'b1;
  endtask

  typedef struct {
    logic en, sh; logic [3:0] d; logic lr;
    logic unl, fail, lo; int cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic en, sh, input logic [3:0] d, input logic lr,
                      input logic unl, fail, lo, input int cnt);
    vec_t v;
    v.en = en; v.sh = sh; v.d = d; v.lr = lr;
    v.unl = unl; v.fail = fail; v.lo = lo; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  int lo_cnt;
  logic [3:0] dsel;
  logic [15:0] tmp;

  initial begin
    Rst = 1'b1; En = 1'b0; Shift_pulse = 1'b0; Lock_req = 1'b0; Digit_in = '0;
`ifdef PASSCODE_PROGRAM_EN
    Set_pulse = 1'b0;
`endif
    model_reset();
    #3;
    do_reset();

    // Correct code, Lock_req+Shift collision, wrong code, retry, stray Lock_req.
    addv(1,1,1,0, 0,0,0,1); addv(1,1,2,0, 0,0,0,2);
    addv(1,1,3,0, 0,0,0,3); addv(1,1,4,0, 0,0,0,4);
    addv(1,0,0,0, 1,0,0,0); addv(1,0,0,0, 1,0,0,0);
    addv(1,1,7,1, 0,0,0,0);
    addv(1,1,1,0, 0,0,0,1); addv(1,1,2,0, 0,0,0,2);
    addv(1,1,3,0, 0,0,0,3); addv(1,1,5,0, 0,0,0,4);
    addv(1,0,0,0, 0,1,0,0); addv(1,0,0,0, 0,0,0,0);
    addv(1,1,1,0, 0,0,0,1); addv(1,1,2,0, 0,0,0,2);
    addv(1,1,3,0, 0,0,0,3); addv(1,1,4,0, 0,0,0,4);
    addv(1,0,0,0, 1,0,0,0); addv(1,0,0,1, 0,0,0,0);
    addv(1,1,1,1, 0,0,0,1); addv(1,0,0,1, 0,0,0,1);
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sh, tbl[i].d, tbl[i].lr);
      chk($sformatf("tbl[%0d] Unlocked", i), int'(Unlocked), int'(tbl[i].unl));
      chk($sformatf("tbl[%0d] Fail", i), int'(Fail), int'(tbl[i].fail));
      chk($sformatf("tbl[%0d] Locked_out", i), int'(Locked_out), int'(tbl[i].lo));
      chk($sformatf("tbl[%0d] Digit_count", i), int'(Digit_count), tbl[i].cnt);
    end

    // Lockout after MAX_TRIES wrong codes; correct code ignored while locked.
    do_reset();
    enter(16'h1111); idle();
    enter(16'h2222); idle();
    enter(16'h3333);
    lo_cnt = 0;
    tmp = DEF_CODE;
    for (int i = 0; i < LOCK + 10; i++) begin
      step(1'b1, 1'b1, tmp[(3 - i % 4) * 4 +: 4], 1'b0);
      if (Locked_out) lo_cnt++;
      else if (lo_cnt > 0) break;
    end
    chk("lockout length", lo_cnt, LOCK);
    chk("no unlock in lockout", int'(Unlocked), 0);
    repeat (2) idle();
    enter(DEF_CODE); idle();
    chk("unlock after lockout", int'(Unlocked), 1);

    // En=0 holds the partial entry; reset mid-entry clears outputs at once.
    do_reset();
    step(1'b1, 1'b1, 4'd1, 1'b0); step(1'b1, 1'b1, 4'd2, 1'b0);
    repeat (3) step(1'b0, 1'b1, 4'd9, 1'b0);
    chk("En=0 hold count", int'(Digit_count), 2);
    step(1'b1, 1'b1, 4'd3, 1'b0); step(1'b1, 1'b1, 4'd4, 1'b0); idle();
    chk("unlock after re-enable", int'(Unlocked), 1);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    step(1'b1, 1'b1, 4'd1, 1'b0); step(1'b1, 1'b1, 4'd2, 1'b0);
    do_reset();

`ifdef PASSCODE_PROGRAM_EN
    enter(DEF_CODE); idle();
    enter(16'h9876);
    chk("prog entry full", int'(Digit_count), 4);
    Set_pulse = 1'b1; idle(); Set_pulse = 1'b0;
    step(1'b1, 1'b0, 4'd0, 1'b1);
    enter(16'h9876); idle();
    chk("new code unlocks", int'(Unlocked), 1);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    enter(DEF_CODE); idle();
    chk("old code fails", int'(Unlocked), 0);
    do_reset();
`endif

    // Random traffic, biased toward the correct next digit so unlocks happen.
    for (int i = 0; i < 1500; i++) begin
      tmp = m_code;
      if ($urandom_range(0, 3) == 0 || m_q.size() >= N) dsel = 4'($urandom_range(0, 9));
      else dsel = tmp[(3 - m_q.size()) * 4 +: 4];
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), dsel,
           1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
